// File: rtl/instr_merge_loader_pkg.sv
// Shared loader definitions: instruction field layout and loader state encoding.
// Field positions must stay in step with the core's instruction bus split.
package instr_merge_loader_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned INSTR_W  = OP_W + DATA_W;
    localparam int unsigned OP_MSB   = INSTR_W - 1;
    localparam int unsigned OP_LSB   = DATA_W;
    localparam int unsigned DATA_MSB = DATA_W - 1;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StGetOp,
        StGetData,
        StWrite,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/instr_merge_loader_if.sv
// Byte-stream input and program-memory write port of the instruction loader.
// The loader masters the memory write port; the environment sources the byte stream.
interface instr_merge_loader_if
    import instr_merge_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);

    logic [DATA_W-1:0]  in_byte;
    logic               in_valid;
    logic               in_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;

    modport master (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/instr_merge_loader.sv
// Packs {opcode, data} byte pairs into instruction words and writes them sequentially
// into program memory, starting at address 0, for prog_len words.
module instr_merge_loader
    import instr_merge_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W:0]      prog_len,
    instr_merge_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    loader_state_e      state_q, state_d;
    logic [ADDR_W:0]    len_q, len_d;
    // Word count doubles as the write address; the extra MSB lets it reach 2**ADDR_W.
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               rdy;
    logic               xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign rdy  = (state_q == StGetOp) || (state_q == StGetData);
    assign xfer = rdy && bus.in_valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = prog_len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (prog_len == '0) ? StDone : StGetOp;
                end
            end
            StGetOp: begin
                if (xfer) begin
                    if (bus.in_byte[DATA_W-1:OP_W] != '0) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        op_d    = bus.in_byte[OP_W-1:0];
                        state_d = StGetData;
                    end
                end
            end
            StGetData: begin
                if (xfer) begin
                    wdata_d[OP_MSB:OP_LSB]     = op_q;
                    wdata_d[DATA_MSB:DATA_LSB] = bus.in_byte;
                    state_d                    = StWrite;
                end
            end
            StWrite: begin
                cnt_d   = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                state_d = (cnt_d == len_q) ? StDone : StGetOp;
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = rdy;
    assign bus.mem_we    = (state_q == StWrite);
    assign bus.mem_addr  = cnt_q[ADDR_W-1:0];
    assign bus.mem_wdata = wdata_q;
    assign busy          = rdy || (state_q == StWrite);
    assign done          = (state_q == StDone);
    assign err           = err_q;

endmodule

// File: tb/tb_instr_merge_loader.sv
// Drives a wide (ADDR_W=8) and a narrow (ADDR_W=2) loader with the same byte stream and
// checks both against expected write/done/error events produced by a word-level model.
module tb_instr_merge_loader;

    localparam int KWr   = 0;
    localparam int KDone = 1;
    localparam int KErr  = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] plen;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       busy_w, done_w, err_w;
    logic       busy_n, done_n, err_n;

    int   total;
    int   bad;
    ev_t  exp_w[$];
    ev_t  exp_n[$];
    logic [7:0] stim [8];
    logic last_err;
    logic prev_we  [2];
    logic prev_err [2];

    instr_merge_loader_if #(.ADDR_W(8)) bus_w ();
    instr_merge_loader_if #(.ADDR_W(2)) bus_n ();

    assign bus_w.in_byte  = in_byte;
    assign bus_w.in_valid = in_valid;
    assign bus_n.in_byte  = in_byte;
    assign bus_n.in_valid = in_valid;

    instr_merge_loader #(.ADDR_W(8)) u_wide (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .prog_len (plen),
        .bus      (bus_w.master),
        .busy     (busy_w),
        .done     (done_w),
        .err      (err_w)
    );

    instr_merge_loader #(.ADDR_W(2)) u_narrow (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .prog_len (plen[2:0]),
        .bus      (bus_n.master),
        .busy     (busy_n),
        .done     (done_n),
        .err      (err_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every write, done pulse or rising err must match the next expected event.
    task automatic mon(input int i, input logic we, input logic rdy, input logic bsy,
                       input logic dn, input logic er, input int addr, input int wdata);
        ev_t   e;
        int    kind;
        string tag;
        tag = (i == 0) ? "wide" : "narrow";
        if (we || dn || (er && !prev_err[i])) begin
            kind = we ? KWr : (dn ? KDone : KErr);
            if ((i == 0 && exp_w.size() == 0) || (i == 1 && exp_n.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL %s_unexpected_event: got kind %0d addr %0h, required none",
                         tag, kind, addr);
            end else begin
                e = (i == 0) ? exp_w.pop_front() : exp_n.pop_front();
                chk({tag, "_event_kind"}, kind, e.kind);
                if (e.kind != KErr) chk({tag, "_addr"}, addr, e.addr);
                if (we) begin
                    chk({tag, "_wdata"}, wdata, e.data);
                    chk({tag, "_ready_in_write"}, int'(rdy), 0);
                    chk({tag, "_we_single_cycle"}, int'(prev_we[i]), 0);
                end else begin
                    chk({tag, "_busy_at_end"}, int'(bsy), 0);
                end
            end
        end
        prev_we[i]  = we;
        prev_err[i] = er;
    endtask

    always @(negedge clk) begin
        mon(0, bus_w.mem_we, bus_w.in_ready, busy_w, done_w, err_w,
            int'(bus_w.mem_addr), int'(bus_w.mem_wdata));
        mon(1, bus_n.mem_we, bus_n.in_ready, busy_n, done_n, err_n,
            int'(bus_n.mem_addr), int'(bus_n.mem_wdata));
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_w_in_ready"}, int'(bus_w.in_ready), 0);
        chk({tag, "_w_mem_we"}, int'(bus_w.mem_we), 0);
        chk({tag, "_w_mem_addr"}, int'(bus_w.mem_addr), 0);
        chk({tag, "_w_mem_wdata"}, int'(bus_w.mem_wdata), 0);
        chk({tag, "_w_busy_done_err"}, int'({busy_w, done_w, err_w}), 0);
        chk({tag, "_n_in_ready"}, int'(bus_n.in_ready), 0);
        chk({tag, "_n_mem_we"}, int'(bus_n.mem_we), 0);
        chk({tag, "_n_mem_addr"}, int'(bus_n.mem_addr), 0);
        chk({tag, "_n_mem_wdata"}, int'(bus_n.mem_wdata), 0);
        chk({tag, "_n_busy_done_err"}, int'({busy_n, done_n, err_n}), 0);
    endtask

    // stall: 0 = always valid, 1 = toggle valid every cycle, 2 = random valid.
    task automatic run_load(input int n, input int stall, input bit glitch);
        ev_t  e;
        int   nb;
        int   cyc;
        logic errd;
        logic xfer;
        chk("w_err_held", int'(err_w), int'(last_err));
        chk("n_err_held", int'(err_n), int'(last_err));
        nb   = 2 * n;
        errd = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (stim[2*i][7:4] != 4'h0) begin
                e.kind = KErr; e.addr = 0; e.data = 0;
                exp_w.push_back(e);
                exp_n.push_back(e);
                nb   = 2 * i + 1;
                errd = 1'b1;
                break;
            end
            e.kind = KWr;
            e.data = (int'(stim[2*i][3:0]) << 8) | int'(stim[2*i+1]);
            e.addr = i % 256;
            exp_w.push_back(e);
            e.addr = i % 4;
            exp_n.push_back(e);
        end
        if (!errd) begin
            e.kind = KDone; e.data = 0;
            e.addr = n % 256;
            exp_w.push_back(e);
            e.addr = n % 4;
            exp_n.push_back(e);
        end
        plen  = 9'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("w_err_cleared", int'(err_w), 0);
        chk("n_err_cleared", int'(err_n), 0);
        if (n == 0) begin
            chk("w_zero_len_done", int'(done_w), 1);
            chk("n_zero_len_done", int'(done_n), 1);
        end
        for (int k = 0; k < nb; k++) begin
            in_byte = stim[k];
            cyc     = 0;
            forever begin
                if (stall == 0) in_valid = 1'b1;
                else if (stall == 1) in_valid = ~in_valid;
                else in_valid = 1'($urandom_range(0, 1));
                if (glitch && $urandom_range(0, 2) == 0) begin
                    start = 1'b1;
                    plen  = 9'($urandom_range(0, 4));
                end
                #1;
                xfer = in_valid && bus_w.in_ready;
                @(negedge clk);
                start = 1'b0;
                if (xfer) break;
                cyc++;
                if (cyc > 40) begin
                    chk("byte_accept_timeout", cyc, 0);
                    in_valid = 1'b0;
                    return;
                end
            end
            if (k % 2 == 1) begin
                chk("w_we_after_data", int'(bus_w.mem_we), 1);
                chk("n_we_after_data", int'(bus_n.mem_we), 1);
                chk("w_ready_low_write", int'(bus_w.in_ready), 0);
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 12 && (exp_w.size() != 0 || exp_n.size() != 0); c++)
            @(negedge clk);
        @(negedge clk);
        chk("w_events_drained", exp_w.size(), 0);
        chk("n_events_drained", exp_n.size(), 0);
        chk("w_busy_after", int'(busy_w), 0);
        last_err = errd;
        exp_w.delete();
        exp_n.delete();
    endtask

    task automatic set_basic();
        stim[0] = 8'h01; stim[1] = 8'hAA; stim[2] = 8'h02; stim[3] = 8'h55;
        stim[4] = 8'h0F; stim[5] = 8'hFF;
    endtask

    task automatic set_random();
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 9) == 0)
                stim[2*i] = {4'($urandom_range(1, 15)), 4'($urandom)};
            else
                stim[2*i] = {4'h0, 4'($urandom)};
            stim[2*i+1] = 8'($urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required earlier finish");
        $fatal(1);
    end

    initial begin
        total    = 0;
        bad      = 0;
        last_err = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        plen     = '0;
        in_byte  = '0;
        in_valid = 1'b0;
        prev_we  = '{1'b0, 1'b0};
        prev_err = '{1'b0, 1'b0};
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        set_basic();
        run_load(3, 0, 1'b0);
        chk("basic_w_final_addr", int'(bus_w.mem_addr), 3);
        run_load(3, 1, 1'b0);

        stim[0] = 8'h31; stim[1] = 8'h00;
        run_load(2, 0, 1'b0);
        stim[0] = 8'h05; stim[1] = 8'h12; stim[2] = 8'hA0; stim[3] = 8'h77;
        run_load(3, 2, 1'b0);
        set_basic();
        run_load(3, 0, 1'b0);

        run_load(0, 0, 1'b0);
        set_basic();
        run_load(3, 0, 1'b1);

        for (int i = 0; i < 8; i++) stim[i] = 8'((i % 2 == 0) ? i / 2 + 8 : 8'hC0 + i);
        run_load(4, 0, 1'b0);
        chk("wrap_n_addr", int'(bus_n.mem_addr), 0);
        chk("wrap_w_addr", int'(bus_w.mem_addr), 4);

        for (int t = 0; t < 30; t++) begin
            set_random();
            run_load($urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Abandon a load after its opcode byte, then check full reset state.
        plen  = 9'd2;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_byte  = 8'h03;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("midload_reset");
        rst_n    = 1'b1;
        in_valid = 1'b1;
        last_err = 1'b0;
        @(negedge clk);
        chk("post_reset_idle_ready", int'(bus_w.in_ready), 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("final_w_queue_empty", exp_w.size(), 0);
        chk("final_n_queue_empty", exp_n.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
